// File: rtl/load_mtxreg_ctrl_pkg.sv
// Shared HPU definitions for the matrix-register load controller:
// default widths and the controller state encoding.
package load_mtxreg_ctrl_pkg;

    localparam int MRC_IND_WTH_DEF  = 1;
    localparam int MRC_ADDR_WTH_DEF = 9;
    localparam int MR_DATA_WTH_DEF  = 512;
    localparam int LEN_WTH_DEF      = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ldmr_state_e;

endpackage

// File: rtl/load_mtxreg_ctrl.sv
// Matrix-register load controller: accepts a (bank, address, length) command,
// streams DDR beats into consecutive matrix-register lines with a one-cycle
// write latency, and pulses done together with the final write.
module load_mtxreg_ctrl
    import load_mtxreg_ctrl_pkg::*;
#(
    parameter int MRC_IND_WTH  = MRC_IND_WTH_DEF,
    parameter int MRC_ADDR_WTH = MRC_ADDR_WTH_DEF,
    parameter int MR_DATA_WTH  = MR_DATA_WTH_DEF,
    parameter int LEN_WTH      = LEN_WTH_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    ctrl_ldmr__cmd_valid_i,
    output logic                    ldmr_ctrl__cmd_ready_o,
    input  logic [MRC_IND_WTH-1:0]  ctrl_ldmr__cmd_index_i,
    input  logic [MRC_ADDR_WTH-1:0] ctrl_ldmr__cmd_addr_i,
    input  logic [LEN_WTH-1:0]      ctrl_ldmr__cmd_len_i,
    input  logic [MR_DATA_WTH-1:0]  ddr_ldmr__rdata_i,
    input  logic                    ddr_ldmr__rdata_act_i,
    output logic                    ldmr_ddr__rdata_rdy_o,
    output logic [MRC_IND_WTH-1:0]  ldmr_mrc__windex_o,
    output logic [MRC_ADDR_WTH-1:0] ldmr_mrc__waddr_o,
    output logic                    ldmr_mrc__we_o,
    output logic [MR_DATA_WTH-1:0]  ldmr_mrc__wdata_o,
    output logic                    ldmr_mrc__wdata_act_o,
    output logic                    ldmr_ctrl__done_o,
    output logic                    ldmr_ctrl__busy_o
);

    ldmr_state_e state_q, state_nxt;

    logic [MRC_IND_WTH-1:0]  idx_q;
    logic [MRC_ADDR_WTH-1:0] addr_q;
    logic [LEN_WTH-1:0]      len_q;
    logic [LEN_WTH-1:0]      cnt_q;

    logic                    cmd_fire;
    logic                    beat_fire;
    logic                    last_beat;
    logic [MRC_ADDR_WTH-1:0] waddr_nxt;

    logic                    vld_p1;
    logic [MRC_IND_WTH-1:0]  windex_p1;
    logic [MRC_ADDR_WTH-1:0] waddr_p1;
    logic [MR_DATA_WTH-1:0]  wdata_p1;

    assign cmd_fire  = (state_q == ST_IDLE) && ctrl_ldmr__cmd_valid_i;
    assign beat_fire = (state_q == ST_LOAD) && ddr_ldmr__rdata_act_i;
    assign last_beat = (cnt_q == (len_q - LEN_WTH'(1)));
    // Line address wraps naturally at the matrix-register depth.
    assign waddr_nxt = addr_q + MRC_ADDR_WTH'(cnt_q);

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic: a zero-length command goes straight to DONE.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_ldmr__cmd_valid_i) begin
                    state_nxt = (ctrl_ldmr__cmd_len_i != '0) ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD: begin
                if (beat_fire && last_beat) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command latch and beat counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idx_q  <= '0;
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else if (cmd_fire) begin
            idx_q  <= ctrl_ldmr__cmd_index_i;
            addr_q <= ctrl_ldmr__cmd_addr_i;
            len_q  <= ctrl_ldmr__cmd_len_i;
            cnt_q  <= '0;
        end else if (beat_fire) begin
            cnt_q  <= cnt_q + LEN_WTH'(1);
        end
    end

    // Write stage: registers one consumed beat; address/bank/data hold when idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p1    <= 1'b0;
            windex_p1 <= '0;
            waddr_p1  <= '0;
            wdata_p1  <= '0;
        end else begin
            vld_p1 <= beat_fire;
            if (beat_fire) begin
                windex_p1 <= idx_q;
                waddr_p1  <= waddr_nxt;
                wdata_p1  <= ddr_ldmr__rdata_i;
            end
        end
    end

    assign ldmr_ctrl__cmd_ready_o = (state_q == ST_IDLE);
    assign ldmr_ddr__rdata_rdy_o  = (state_q == ST_LOAD);
    assign ldmr_ctrl__busy_o      = (state_q == ST_LOAD) || (state_q == ST_DONE);
    assign ldmr_ctrl__done_o      = (state_q == ST_DONE);

    assign ldmr_mrc__we_o         = vld_p1;
    assign ldmr_mrc__wdata_act_o  = vld_p1;
    assign ldmr_mrc__windex_o     = windex_p1;
    assign ldmr_mrc__waddr_o      = waddr_p1;
    assign ldmr_mrc__wdata_o      = wdata_p1;

endmodule

// File: tb/tb_load_mtxreg_ctrl.sv
// Directed bench for the matrix-register load controller.
module tb_load_mtxreg_ctrl;

    localparam int IW = 1;
    localparam int AW = 9;
    localparam int DW = 512;
    localparam int LW = 10;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IW-1:0] cmd_index;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] rdata;
    logic          rdata_act;
    logic          rdata_rdy;
    logic [IW-1:0] windex;
    logic [AW-1:0] waddr;
    logic          we;
    logic [DW-1:0] wdata;
    logic          wdata_act;
    logic          done;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;
    logic [IW-1:0] last_idx;

    load_mtxreg_ctrl #(
        .MRC_IND_WTH (IW),
        .MRC_ADDR_WTH(AW),
        .MR_DATA_WTH (DW),
        .LEN_WTH     (LW)
    ) dut (
        .clk_i                 (clk),
        .rst_n_i               (rst_n),
        .ctrl_ldmr__cmd_valid_i(cmd_valid),
        .ldmr_ctrl__cmd_ready_o(cmd_ready),
        .ctrl_ldmr__cmd_index_i(cmd_index),
        .ctrl_ldmr__cmd_addr_i (cmd_addr),
        .ctrl_ldmr__cmd_len_i  (cmd_len),
        .ddr_ldmr__rdata_i     (rdata),
        .ddr_ldmr__rdata_act_i (rdata_act),
        .ldmr_ddr__rdata_rdy_o (rdata_rdy),
        .ldmr_mrc__windex_o    (windex),
        .ldmr_mrc__waddr_o     (waddr),
        .ldmr_mrc__we_o        (we),
        .ldmr_mrc__wdata_o     (wdata),
        .ldmr_mrc__wdata_act_o (wdata_act),
        .ldmr_ctrl__done_o     (done),
        .ldmr_ctrl__busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [DW-1:0] beat_val(input int n);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(n);
        return {16{w}};
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic [IW-1:0] idx, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        chk("cmd_ready_pre", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_index = idx;
        cmd_addr  = addr;
        cmd_len   = len;
        step();
        cmd_valid = 1'b0;
        chk("busy_after_cmd", busy, 1'b1);
        chk("ready_after_cmd", cmd_ready, 1'b0);
        chk("rdy_after_cmd", rdata_rdy, (len != 0));
        chk("we_after_cmd", we, 1'b0);
    endtask

    // Drive an act pattern (bit j = cycle j) and check every cycle's write port.
    task automatic run_pattern(input logic [IW-1:0] idx, input logic [AW-1:0] addr, input int len,
                               input int n, input logic [31:0] pat, input int dbase);
        bit in_load;
        bit fire;
        bit last;
        int cnt;
        in_load = 1'b1;
        cnt = 0;
        for (int j = 0; j < n; j++) begin
            rdata_act = pat[j];
            rdata     = beat_val(dbase + j);
            fire = pat[j] && in_load;
            last = fire && (cnt == len - 1);
            if (fire) begin
                last_addr = AW'(int'(addr) + cnt);
                last_data = beat_val(dbase + j);
                last_idx  = idx;
            end
            step();
            chk("we", we, fire);
            chk("wdata_act", wdata_act, fire);
            chk("waddr", waddr, last_addr);
            chk("wdata", wdata, last_data);
            chk("windex", windex, last_idx);
            chk("done", done, last);
            if (fire) cnt++;
            if (last) in_load = 1'b0;
            chk("rdy", rdata_rdy, in_load);
        end
        rdata_act = 1'b0;
        chk("beats_written", cnt, len);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_index = '0;
        cmd_addr  = '0;
        cmd_len   = '0;
        rdata     = '0;
        rdata_act = 1'b0;
        last_addr = '0;
        last_data = '0;
        last_idx  = '0;

        // Reset state
        step();
        chk("rst_we", we, 1'b0);
        chk("rst_wdata_act", wdata_act, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_waddr", waddr, '0);
        chk("rst_windex", windex, '0);
        chk("rst_wdata", wdata, '0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_rdy", rdata_rdy, 1'b0);
        rst_n = 1'b1;
        step();

        // Beats offered while idle are ignored
        rdata_act = 1'b1;
        rdata     = beat_val(99);
        step();
        rdata_act = 1'b0;
        chk("idle_act_we", we, 1'b0);
        chk("idle_act_wdata", wdata, '0);

        // Basic: bank 1, 0x010, four back-to-back beats
        issue_cmd(1'b1, 9'h010, 10'd4);
        run_pattern(1'b1, 9'h010, 4, 4, 32'b1111, 0);
        chk("basic_last_addr", waddr, 9'h013);
        step();
        chk("basic_idle_ready", cmd_ready, 1'b1);
        chk("basic_idle_busy", busy, 1'b0);
        chk("basic_done_clr", done, 1'b0);
        chk("basic_hold_addr", waddr, 9'h013);

        // Wrap: 0x1FE, 0x1FF, 0x000
        issue_cmd(1'b0, 9'h1FE, 10'd3);
        run_pattern(1'b0, 9'h1FE, 3, 3, 32'b111, 10);
        chk("wrap_last_addr", waddr, 9'h000);
        step();

        // Bubbles: act 1,0,0,1,0,1
        issue_cmd(1'b1, 9'h040, 10'd3);
        run_pattern(1'b1, 9'h040, 3, 6, 32'b101001, 20);
        chk("bubble_last_addr", waddr, 9'h042);
        step();

        // Zero length: no write, done pulse from DONE then back to idle
        issue_cmd(1'b0, 9'h080, 10'd0);
        chk("zero_done", done, 1'b1);
        chk("zero_we", we, 1'b0);
        step();
        chk("zero_done_clr", done, 1'b0);
        chk("zero_ready", cmd_ready, 1'b1);
        chk("zero_we2", we, 1'b0);

        // Extra beat after a len-2 load is refused
        issue_cmd(1'b1, 9'h100, 10'd2);
        run_pattern(1'b1, 9'h100, 2, 4, 32'b0111, 30);
        chk("extra_last_addr", waddr, 9'h101);
        step();

        // Reset abort during a len-8 load
        issue_cmd(1'b1, 9'h020, 10'd8);
        rdata_act = 1'b1;
        rdata = beat_val(40);
        step();
        rdata = beat_val(41);
        step();
        rdata_act = 1'b0;
        chk("abort_we_pre", we, 1'b1);
        chk("abort_waddr_pre", waddr, 9'h021);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_we", we, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_waddr", waddr, '0);
        chk("abort_wdata", wdata, '0);
        chk("abort_windex", windex, '0);
        step();
        chk("abort_held_done", done, 1'b0);
        #1;
        rst_n = 1'b1;
        last_addr = '0;
        last_data = '0;
        last_idx  = '0;
        issue_cmd(1'b0, 9'h033, 10'd1);
        run_pattern(1'b0, 9'h033, 1, 2, 32'b01, 50);
        chk("post_abort_addr", waddr, 9'h033);
        step();
        chk("post_abort_ready", cmd_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
